// File: rtl/ms_accum_if.sv
// ms_accum_if: sample input and mean-square result bus of ms_accum
interface ms_accum_if #(parameter int DATA_W = 10);
   logic signed [DATA_W-1:0] din;
   logic din_valid;
   logic [2*DATA_W-1:0] ms_out;
   logic ms_valid;
   logic clip;
   modport master(output din, din_valid, input ms_out, ms_valid, clip);
   modport slave(input din, din_valid, output ms_out, ms_valid, clip);
endinterface

// File: rtl/ms_accum.sv
// ms_accum: windowed mean-square accumulator; define MS_ACCUM_CLIP_EN to add the full-scale clip flag
module ms_accum #(
   parameter int DATA_W = 10,
   parameter int LOG2_WIN = 8
) (
   input logic clk,
   input logic sclr,
   ms_accum_if.slave bus
);
   localparam int W = 2*DATA_W;
   localparam int AW = W + LOG2_WIN;
   logic signed [DATA_W-1:0] s1_data;
   logic s1_v, s2_v, ms_valid, last;
   logic signed [W-1:0] prod;
   logic [W-1:0] sq, ms_out;
   logic [AW-1:0] acc, acc_next;
   logic [LOG2_WIN-1:0] cnt;
   assign prod = W'(s1_data) * W'(s1_data);
   assign acc_next = acc + AW'(sq);
   assign last = s2_v && &cnt;
   assign bus.ms_out = ms_out;
   assign bus.ms_valid = ms_valid;
   always_ff @(posedge clk) begin
      if (sclr) begin
         s1_data <= '0;
         s1_v <= 1'b0;
         s2_v <= 1'b0;
         sq <= '0;
         acc <= '0;
         cnt <= '0;
         ms_out <= '0;
         ms_valid <= 1'b0;
      end else begin
         s1_data <= bus.din;
         s1_v <= bus.din_valid;
         s2_v <= s1_v;
         sq <= prod;
         ms_valid <= last;
         if (s2_v) begin
            cnt <= cnt + 1'b1;
            acc <= last ? '0 : acc_next;
         end
         if (last) ms_out <= acc_next[AW-1:LOG2_WIN];
      end
   end
`ifdef MS_ACCUM_CLIP_EN
   localparam logic signed [DATA_W-1:0] d_min = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic signed [DATA_W-1:0] d_max = ~d_min;
   logic s1_flag, s2_flag, sticky, clip;
   assign bus.clip = clip;
   // flags only valid samples so idle bus values never mark a window
   always_ff @(posedge clk) begin
      if (sclr) begin
         s1_flag <= 1'b0;
         s2_flag <= 1'b0;
         sticky <= 1'b0;
         clip <= 1'b0;
      end else begin
         s1_flag <= bus.din_valid && (bus.din == d_min || bus.din == d_max);
         s2_flag <= s1_flag;
         if (last) begin
            clip <= sticky | s2_flag;
            sticky <= 1'b0;
         end else if (s2_v) sticky <= sticky | s2_flag;
      end
   end
`else
   assign bus.clip = 1'b0;
`endif
endmodule

// File: tb/tb_ms_accum.sv
// tb_ms_accum: directed self-checking bench for ms_accum
module tb_ms_accum;
`ifdef MS_ACCUM_CLIP_EN
   localparam bit clip_en = 1'b1;
`else
   localparam bit clip_en = 1'b0;
`endif
   logic clk, sclr;
   int cyc, vectors, miscompares, pulses, cap;
   int last_pc, prev_pc;
   logic [19:0] last_out, prev_out;
   logic last_clip;
   ms_accum_if #(.DATA_W(10)) bus ();
   ms_accum #(.DATA_W(10), .LOG2_WIN(8)) dut (.clk(clk), .sclr(sclr), .bus(bus));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   always @(negedge clk) begin
      if (bus.ms_valid) begin
         pulses++;
         prev_pc = last_pc;
         prev_out = last_out;
         last_pc = cyc;
         last_out = bus.ms_out;
         last_clip = bus.clip;
      end
   end
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   task automatic send(input int v, input bit vld);
      bus.din = 10'(v);
      bus.din_valid = vld;
      @(posedge clk);
      #1;
   endtask
   task automatic feed(input int v, input int n);
      repeat (n) send(v, 1'b1);
      cap = cyc;
   endtask
   task automatic idle(input int n);
      repeat (n) send(0, 1'b0);
   endtask
   task automatic window_check(input string tag, input int p0, input int exp_out, input bit exp_clip);
      check({tag, "_pulses"}, 32'(pulses), 32'(p0 + 1));
      check({tag, "_latency"}, 32'(last_pc), 32'(cap + 2));
      check({tag, "_ms_out"}, 32'(last_out), 32'(exp_out));
      check({tag, "_clip"}, 32'(last_clip), 32'(exp_clip));
   endtask
   initial begin
      int p0;
      bus.din = '0;
      bus.din_valid = 1'b0;
      sclr = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ms_out", 32'(bus.ms_out), 32'd0);
      check("rst_ms_valid", 32'(bus.ms_valid), 32'd0);
      check("rst_clip", 32'(bus.clip), 32'd0);
      sclr = 1'b0;
      idle(2);
      p0 = pulses;
      feed(100, 256);
      idle(4);
      window_check("w100", p0, 10000, 1'b0);
      check("w100_hold", 32'(bus.ms_out), 32'd10000);
      check("w100_valid_low", 32'(bus.ms_valid), 32'd0);
      p0 = pulses;
      feed(-512, 256);
      idle(4);
      window_check("wneg512", p0, 262144, clip_en);
      check("wneg512_clip_hold", 32'(bus.clip), 32'(clip_en));
      p0 = pulses;
      feed(1, 256);
      idle(4);
      window_check("w1", p0, 1, 1'b0);
      p0 = pulses;
      feed(0, 128);
      feed(16, 128);
      idle(4);
      window_check("w0_16", p0, 128, 1'b0);
      p0 = pulses;
      for (int i = 0; i < 256; i++) send((i % 2) ? -3 : 3, 1'b1);
      for (int i = 0; i < 256; i++) send((i % 2) ? 4 : 3, 1'b1);
      cap = cyc;
      idle(4);
      check("b2b_pulses", 32'(pulses), 32'(p0 + 2));
      check("b2b_first_out", 32'(prev_out), 32'd9);
      check("b2b_trunc_out", 32'(last_out), 32'd12);
      check("b2b_spacing", 32'(last_pc - prev_pc), 32'd256);
      check("b2b_latency", 32'(last_pc), 32'(cap + 2));
      p0 = pulses;
      for (int i = 0; i < 256; i++) begin
         send(5, 1'b1);
         cap = cyc;
         send(511, 1'b0);
      end
      idle(4);
      window_check("wtoggle", p0, 25, 1'b0);
      feed(50, 100);
      sclr = 1'b1;
      send(50, 1'b1);
      check("sclr_ms_out", 32'(bus.ms_out), 32'd0);
      check("sclr_ms_valid", 32'(bus.ms_valid), 32'd0);
      check("sclr_clip", 32'(bus.clip), 32'd0);
      sclr = 1'b0;
      p0 = pulses;
      idle(1);
      check("post_sclr_ms_out", 32'(bus.ms_out), 32'd0);
      check("post_sclr_ms_valid", 32'(bus.ms_valid), 32'd0);
      feed(7, 256);
      idle(4);
      window_check("w7", p0, 49, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
